alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter PRIO_FIXED, default 0; 0 = round-robin grant, 1 = requester 0 always wins.
REQ-002 SHALL have port i_clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_req_valid  input  2  per-requester request valid, bit r = requester r.
REQ-005 SHALL have port o_req_ready  output  2  per-requester request accept.
REQ-006 SHALL have port i_req_op  input  2 x ALUSel_e  per-requester ALU operation.
REQ-007 SHALL have port i_req_a  input  2 x 32  per-requester operand A.
REQ-008 SHALL have port i_req_b  input  2 x 32  per-requester operand B.
REQ-009 SHALL have port o_rsp_valid  output  2  one-hot response valid to owning requester.
REQ-010 SHALL have port i_rsp_ready  input  2  per-requester response accept.
REQ-011 SHALL have port o_rsp_data  output  32  shared response data (ALU result).
REQ-012 SHALL have port o_alu_op  output  ALUSel_e  operation driven to shared ALU.
REQ-013 SHALL have ports o_alu_a, o_alu_b  output  32 each  operands driven to shared ALU.
REQ-014 SHALL have port i_alu_res  input  32  combinational result from shared ALU.

Function
REQ-015 SHALL implement FSM states IDLE, EXEC, RESP; one transaction in flight at a time.
REQ-016 IDLE: if any i_req_valid set, SHALL select grant g, assert o_req_ready[g] combinationally that cycle, latch op/a/b of g and g itself, go to EXEC; else stay IDLE.
REQ-017 o_req_ready SHALL be 2'b00 in EXEC and RESP and for the non-granted requester; a handshake completes only when valid & ready both high.
REQ-018 Round-robin (PRIO_FIXED=0): single valid -> that requester; both valid -> requester named by pointer; pointer SHALL then point to the other requester; pointer unchanged when idle.
REQ-019 PRIO_FIXED=1: both valid -> requester 0; pointer ignored.
REQ-020 EXEC: o_alu_op/o_alu_a/o_alu_b SHALL equal latched values; i_alu_res SHALL be captured into response register at end of cycle; go to RESP.
REQ-021 In IDLE and RESP the ALU outputs SHALL hold latched values of last transaction (ALU_ADD/0/0 before any).
REQ-022 RESP: o_rsp_valid SHALL be one-hot at bit g, o_rsp_data = captured result, both stable until i_rsp_ready[g]; on handshake go to IDLE next cycle.
REQ-023 i_rsp_ready of non-owner SHALL be ignored; o_rsp_valid SHALL be 2'b00 outside RESP.
REQ-024 Latency: request accepted cycle N -> o_rsp_valid high cycle N+2; max throughput one transaction per 3 cycles.
REQ-025 Requester dropping i_req_valid before handshake SHALL not be granted; changes to i_req_* after accept SHALL not affect the in-flight result.

Reset
REQ-026 On i_rst_n low, immediately: state IDLE, pointer 0, latched op ALU_ADD, latched a/b 0, response register 0, o_rsp_valid 2'b00, o_req_ready 2'b00.
REQ-027 Reset asserted in EXEC or RESP SHALL abort the transaction with no response delivered; first grant after release follows pointer 0.

Verification
REQ-028 Req0 only: ADD a=5 b=7 accepted cycle N -> o_rsp_valid=2'b01, o_rsp_data=12 at N+2.
REQ-029 Both valid continuously, RR, req0 SUB 10-3, req1 SLT -1<1 -> grants 0,1,0,1 alternate; data 7 then 1.
REQ-030 PRIO_FIXED=1, both valid continuously -> every grant to requester 0; requester 1 never granted.
REQ-031 Req1 SRA 0x80000000 by 4, i_rsp_ready[1] low 5 cycles -> o_rsp_valid=2'b10, data 0xF8000000 held stable all 5 cycles; i_rsp_ready[0] high has no effect.
REQ-032 Reset pulsed during EXEC -> all outputs reset values within the reset cycle; no o_rsp_valid for aborted request.
REQ-033 Bench SHALL check every response against a golden ALU model of the latched op/a/b.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// ALU operation encoding shared by the arbiter and its users.
package alu_arbiter_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } ALUSel_e;

endpackage

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a single shared combinational ALU.
// Exactly one transaction is in flight at a time. The ALU sees the latched
// operation and operands. Its result is captured, then returned to the owner
// with a valid/ready handshake.
//
// Ports
//   i_clk, i_rst_n         clock, async active-low reset
//   i_req_valid/o_req_ready per-requester request handshake
//   i_req_op/a/b           per-requester operation and operands
//   o_rsp_valid            one-hot response valid (owner only)
//   i_rsp_ready            per-requester response accept
//   o_rsp_data             captured ALU result
//   o_alu_op/a/b           drive to the shared ALU
//   i_alu_res              shared ALU result (combinational)
//
// state | meaning
// IDLE  | waiting for a request; grant and latch on the first valid
// EXEC  | ALU driven with latched op/operands; result captured at cycle end
// RESP  | result offered to the owner until it accepts
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter bit PRIO_FIXED = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [1:0]       i_req_valid,
  output logic [1:0]       o_req_ready,
  input  ALUSel_e [1:0]    i_req_op,
  input  logic [1:0][31:0] i_req_a,
  input  logic [1:0][31:0] i_req_b,
  output logic [1:0]       o_rsp_valid,
  input  logic [1:0]       i_rsp_ready,
  output logic [31:0]      o_rsp_data,
  output ALUSel_e          o_alu_op,
  output logic [31:0]      o_alu_a,
  output logic [31:0]      o_alu_b,
  input  logic [31:0]      i_alu_res
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        ptr_q, ptr_d;
  logic        gnt_q, gnt_d;
  ALUSel_e     op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] res_q, res_d;
  logic        gnt_sel;

  // Contention resolves via the round-robin pointer, or to requester 0
  // when fixed priority is selected.
  always_comb begin
    gnt_sel = 1'b0;
    case (i_req_valid)
      2'b01:   gnt_sel = 1'b0;
      2'b10:   gnt_sel = 1'b1;
      2'b11:   gnt_sel = PRIO_FIXED ? 1'b0 : ptr_q;
      default: gnt_sel = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    o_req_ready = 2'b00;
    o_rsp_valid = 2'b00;
    case (state_q)
      IDLE: begin
        // Ready is gated by reset so that no handshake is offered
        // while reset is held, even with requests pending.
        if ((|i_req_valid) && i_rst_n) begin
          o_req_ready[gnt_sel] = 1'b1;
          gnt_d                = gnt_sel;
          op_d                 = i_req_op[gnt_sel];
          a_d                  = i_req_a[gnt_sel];
          b_d                  = i_req_b[gnt_sel];
          ptr_d                = ~gnt_sel;
          state_d              = EXEC;
        end
      end
      EXEC: begin
        res_d   = i_alu_res;
        state_d = RESP;
      end
      RESP: begin
        o_rsp_valid[gnt_q] = 1'b1;
        if (i_rsp_ready[gnt_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      gnt_q   <= 1'b0;
      op_q    <= ALU_ADD;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      res_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end

  assign o_alu_op   = op_q;
  assign o_alu_a    = a_q;
  assign o_alu_b    = b_q;
  assign o_rsp_data = res_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench: a round-robin and a fixed-priority arbiter share one stimulus.
// Each is compared against a transaction-level model that works from
// grant rules, accept cycle + 2 latency and a golden ALU function.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       req_valid;
  ALUSel_e [1:0]    req_op;
  logic [1:0][31:0] req_a;
  logic [1:0][31:0] req_b;
  logic [1:0]       rsp_ready;

  logic [1:0]  req_ready [2];
  logic [1:0]  rsp_valid [2];
  logic [31:0] rsp_data  [2];
  ALUSel_e     alu_op    [2];
  logic [31:0] alu_a     [2];
  logic [31:0] alu_b     [2];
  logic [31:0] alu_res   [2];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // model state per instance (0 = round-robin, 1 = fixed priority)
  bit          m_busy [2];
  int          m_acc  [2];
  bit          m_own  [2];
  logic [31:0] m_res  [2];
  bit          m_ptr  [2];
  ALUSel_e     m_lop  [2];
  logic [31:0] m_la   [2];
  logic [31:0] m_lb   [2];

  int          gnt_log [$];
  logic [31:0] rsp_log [$];
  int          fx_g0, fx_g1;

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(ALUSel_e op, logic [31:0] a, logic [31:0] b);
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_SLL:  return a << b[4:0];
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return $unsigned($signed(a) >>> b[4:0]);
      ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      default:  return 32'd0;
    endcase
  endfunction

  assign alu_res[0] = alu_f(alu_op[0], alu_a[0], alu_b[0]);
  assign alu_res[1] = alu_f(alu_op[1], alu_a[1], alu_b[1]);

  alu_arbiter #(.PRIO_FIXED(1'b0)) dut_rr (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready[0]),
    .i_req_op(req_op), .i_req_a(req_a), .i_req_b(req_b),
    .o_rsp_valid(rsp_valid[0]), .i_rsp_ready(rsp_ready), .o_rsp_data(rsp_data[0]),
    .o_alu_op(alu_op[0]), .o_alu_a(alu_a[0]), .o_alu_b(alu_b[0]),
    .i_alu_res(alu_res[0])
  );

  alu_arbiter #(.PRIO_FIXED(1'b1)) dut_fx (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready[1]),
    .i_req_op(req_op), .i_req_a(req_a), .i_req_b(req_b),
    .o_rsp_valid(rsp_valid[1]), .i_rsp_ready(rsp_ready), .o_rsp_data(rsp_data[1]),
    .o_alu_op(alu_op[1]), .o_alu_a(alu_a[1]), .o_alu_b(alu_b[1]),
    .i_alu_res(alu_res[1])
  );

  task automatic chk(string tag, int k, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s[%0d] observed=%08h expected=%08h", tag, k, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 1'b0;
      m_acc[k]  = 0;
      m_own[k]  = 1'b0;
      m_res[k]  = 32'd0;
      m_ptr[k]  = 1'b0;
      m_lop[k]  = ALU_ADD;
      m_la[k]   = 32'd0;
      m_lb[k]   = 32'd0;
    end
  endtask

  function automatic bit exp_gnt(int k, logic [1:0] v);
    if (v == 2'b01) return 1'b0;
    if (v == 2'b10) return 1'b1;
    return (k == 1) ? 1'b0 : m_ptr[k];
  endfunction

  task automatic check_reset_outputs(string tag);
    for (int k = 0; k < 2; k++) begin
      chk({tag, "_req_ready"}, k, {30'd0, req_ready[k]}, 32'd0);
      chk({tag, "_rsp_valid"}, k, {30'd0, rsp_valid[k]}, 32'd0);
      chk({tag, "_rsp_data"},  k, rsp_data[k], 32'd0);
      chk({tag, "_alu_op"},    k, {28'd0, alu_op[k]}, {28'd0, ALU_ADD});
      chk({tag, "_alu_a"},     k, alu_a[k], 32'd0);
      chk({tag, "_alu_b"},     k, alu_b[k], 32'd0);
    end
  endtask

  // One clock cycle: drive, check both instances against the model,
  // advance the model across the coming edge, then move to the next cycle.
  task automatic step(logic [1:0] v, ALUSel_e op0, logic [31:0] a0, logic [31:0] b0,
                      ALUSel_e op1, logic [31:0] a1, logic [31:0] b1, logic [1:0] rr);
    req_valid = v;
    req_op[0] = op0; req_a[0] = a0; req_b[0] = b0;
    req_op[1] = op1; req_a[1] = a1; req_b[1] = b1;
    rsp_ready = rr;
    #1;
    for (int k = 0; k < 2; k++) begin
      logic [1:0] e_rdy;
      logic [1:0] e_rv;
      bit         g;
      bit         resp_now;
      e_rdy    = 2'b00;
      e_rv     = 2'b00;
      g        = 1'b0;
      resp_now = m_busy[k] && (cyc >= m_acc[k] + 2);
      if (!m_busy[k] && v != 2'b00) begin
        g        = exp_gnt(k, v);
        e_rdy[g] = 1'b1;
      end
      if (resp_now) e_rv[m_own[k]] = 1'b1;
      chk("req_ready", k, {30'd0, req_ready[k]}, {30'd0, e_rdy});
      chk("rsp_valid", k, {30'd0, rsp_valid[k]}, {30'd0, e_rv});
      if (resp_now) chk("rsp_data", k, rsp_data[k], m_res[k]);
      chk("alu_op", k, {28'd0, alu_op[k]}, {28'd0, m_lop[k]});
      chk("alu_a", k, alu_a[k], m_la[k]);
      chk("alu_b", k, alu_b[k], m_lb[k]);
      if (k == 0 && req_ready[0] != 2'b00) gnt_log.push_back(int'(req_ready[0][1]));
      if (k == 0 && (rsp_valid[0] & rr) != 2'b00) rsp_log.push_back(rsp_data[0]);
      if (k == 1 && req_ready[1][0]) fx_g0++;
      if (k == 1 && req_ready[1][1]) fx_g1++;
      if (!m_busy[k] && v != 2'b00) begin
        m_busy[k] = 1'b1;
        m_own[k]  = g;
        m_acc[k]  = cyc;
        m_lop[k]  = g ? op1 : op0;
        m_la[k]   = g ? a1 : a0;
        m_lb[k]   = g ? b1 : b0;
        m_res[k]  = alu_f(m_lop[k], m_la[k], m_lb[k]);
        m_ptr[k]  = ~g;
      end else if (resp_now && rr[m_own[k]]) begin
        m_busy[k] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(logic [1:0] rr);
    step(2'b00, ALU_ADD, 32'd0, 32'd0, ALU_ADD, 32'd0, 32'd0, rr);
  endtask

  initial begin
    model_reset();
    fx_g0     = 0;
    fx_g1     = 0;
    rst_n     = 1'b0;
    req_valid = 2'b11;
    req_op[0] = ALU_SUB; req_op[1] = ALU_XOR;
    req_a     = '{32'd3, 32'd4};
    req_b     = '{32'd5, 32'd6};
    rsp_ready = 2'b11;
    #2;
    check_reset_outputs("por");
    req_valid = 2'b00;
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // req0 ADD 5+7
    step(2'b01, ALU_ADD, 32'd5, 32'd7, ALU_ADD, 32'd0, 32'd0, 2'b00);
    idle(2'b00);
    chk("add_rsp_valid", 0, {30'd0, rsp_valid[0]}, 32'd1);
    chk("add_rsp_data", 0, rsp_data[0], 32'd12);
    idle(2'b01);
    idle(2'b00);

    // req1 SRA held 5 cycles, non-owner ready high
    step(2'b10, ALU_ADD, 32'd0, 32'd0, ALU_SRA, 32'h8000_0000, 32'd4, 2'b00);
    idle(2'b01);
    for (int i = 0; i < 5; i++) begin
      chk("sra_rsp_valid", i, {30'd0, rsp_valid[0]}, 32'd2);
      chk("sra_rsp_data", i, rsp_data[0], 32'hF800_0000);
      idle(2'b01);
    end
    idle(2'b10);
    idle(2'b00);

    // reset pulse during EXEC aborts the transaction
    step(2'b01, ALU_XOR, 32'h00FF_00FF, 32'h0F0F_0F0F, ALU_ADD, 32'd0, 32'd0, 2'b00);
    #1;
    req_valid = 2'b11;
    rst_n     = 1'b0;
    #1;
    check_reset_outputs("rst_exec");
    #1;
    req_valid = 2'b00;
    rst_n     = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 4; i++) idle(2'b11);

    // both valid continuously
    gnt_log.delete();
    rsp_log.delete();
    fx_g0 = 0;
    fx_g1 = 0;
    for (int i = 0; i < 12; i++) begin
      step(2'b11, ALU_SUB, 32'd10, 32'd3, ALU_SLT, 32'hFFFF_FFFF, 32'd1, 2'b11);
    end
    chk("rr_grant_count", 0, gnt_log.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < gnt_log.size()) chk("rr_grant_seq", i, gnt_log[i], i % 2);
    end
    chk("rr_rsp_count", 0, rsp_log.size(), 32'd4);
    if (rsp_log.size() >= 2) begin
      chk("rr_rsp_first", 0, rsp_log[0], 32'd7);
      chk("rr_rsp_second", 1, rsp_log[1], 32'd1);
    end
    chk("fx_grants_req1", 1, fx_g1, 32'd0);
    chk("fx_grants_req0", 1, fx_g0, 32'd4);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] bb0, bb1;
      bb0 = $urandom;
      bb1 = $urandom;
      if ($urandom_range(0, 1) == 0) bb0 = $urandom_range(0, 40);
      if ($urandom_range(0, 1) == 0) bb1 = $urandom_range(0, 40);
      step(2'($urandom_range(0, 3)),
           ALUSel_e'($urandom_range(0, 9)), $urandom, bb0,
           ALUSel_e'($urandom_range(0, 9)), $urandom, bb1,
           2'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
